// File: rtl/intc_gen2_pkg.sv
// -----------------------------------------------------------------------------
// intc_gen2_pkg
// Shared types and constants for the second-generation interrupt controller.
//   bus_state_e  : register-bus access FSM states (BIDLE -> BACC -> BHOLD)
//   svc_state_e  : interrupt service FSM states (IDLE -> ISSUE -> WAIT)
//   *_BASE/_ADDR : register map base addresses
// -----------------------------------------------------------------------------
package intc_gen2_pkg;

   typedef enum logic [1:0] {
      BIDLE = 2'd0,
      BACC  = 2'd1,
      BHOLD = 2'd2
   } bus_state_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } svc_state_e;

   localparam logic [7:0] PRIO_BASE   = 8'h00;
   localparam logic [7:0] EN_BASE     = 8'h80;
   localparam logic [7:0] MODE_BASE   = 8'hA0;
   localparam logic [7:0] PEND_BASE   = 8'hC0;
   localparam logic [7:0] STATUS_ADDR = 8'hE0;

endpackage

// File: rtl/intc_prio_arb.sv
// -----------------------------------------------------------------------------
// intc_prio_arb
// Combinational winner search over the eligible sources.
//   elig     : eligible source vector (pend & enable)
//   prio     : per-source priority values, larger = more urgent
//   found    : at least one source is eligible
//   win_id   : index of the winning source
//   win_prio : priority value of the winning source
// Ties resolve to the lowest index because a later source only replaces the
// current candidate when its priority is strictly greater.
// -----------------------------------------------------------------------------
module intc_prio_arb #(
   parameter int NUM_INTR = 16,
   parameter int PRIO_W   = 4,
   parameter int ID_W     = $clog2(NUM_INTR)
) (
   input  logic [NUM_INTR-1:0]             elig,
   input  logic [NUM_INTR-1:0][PRIO_W-1:0] prio,
   output logic                            found,
   output logic [ID_W-1:0]                 win_id,
   output logic [PRIO_W-1:0]               win_prio
);

   always_comb begin
      found    = 1'b0;
      win_id   = '0;
      win_prio = '0;
      for (int i = 0; i < NUM_INTR; i++) begin
         if (elig[i] && (!found || (prio[i] > win_prio))) begin
            found    = 1'b1;
            win_id   = ID_W'(i);
            win_prio = prio[i];
         end
      end
   end

endmodule

// File: rtl/intc_gen2.sv
// -----------------------------------------------------------------------------
// intc_gen2
// Prioritised interrupt controller with per-source enable, edge/level capture
// and a byte-wide register bus.
//
// Ports
//   pclk_i, prst_n_i          : clock, asynchronous active-low reset
//   paddr_i/pwdata_i/pwrite_i : register address, write data, direction
//   penable_i                 : access request
//   prdata_o/pready_o         : read data / access complete
//   pslverr_o                 : unmapped address or write to STATUS
//   intr_to_service_o         : ID being presented to the processor
//   intr_valid_o              : an ID is being presented
//   intr_serviced_i           : processor acknowledge of the presented ID
//   intr_active_i             : peripheral requests (synchronous to pclk_i)
//
// Bus handshake: the master raises penable_i with address/data/direction
// stable and holds them until it sees pready_o=1. pready_o rises one cycle
// later (BACC) together with prdata_o/pslverr_o, a write is committed once at
// the end of BACC, and pready_o stays high (BHOLD) until the master drops
// penable_i; the next access may start once pready_o has fallen.
//
// Build option: define INTC_PREEMPT_EN to let a strictly higher-priority
// eligible source replace the presented ID while waiting for acknowledge.
// Without it the presented ID is frozen until acknowledged.
//
// The FSM states and the current arbitration result are collected in the
// internal struct `dbg` for observation.
// -----------------------------------------------------------------------------
module intc_gen2
   import intc_gen2_pkg::*;
#(
   parameter int NUM_INTR = 16,
   parameter int PRIO_W   = 4,
   parameter int ID_W     = $clog2(NUM_INTR)
) (
   input  logic                pclk_i,
   input  logic                prst_n_i,
   input  logic [7:0]          paddr_i,
   input  logic [7:0]          pwdata_i,
   input  logic                pwrite_i,
   input  logic                penable_i,
   output logic [7:0]          prdata_o,
   output logic                pready_o,
   output logic                pslverr_o,
   output logic [ID_W-1:0]     intr_to_service_o,
   output logic                intr_valid_o,
   input  logic                intr_serviced_i,
   input  logic [NUM_INTR-1:0] intr_active_i
);

   localparam int NB = NUM_INTR / 8;

   typedef struct packed {
      bus_state_e        bus;
      svc_state_e        svc;
      logic              found;
      logic [PRIO_W-1:0] win_prio;
   } dbg_t;

   bus_state_e                      bus_q;
   svc_state_e                      svc_q;
   logic [NUM_INTR-1:0][PRIO_W-1:0] prio_q;
   logic [NUM_INTR-1:0]             en_q;
   logic [NUM_INTR-1:0]             mode_q;
   logic [NUM_INTR-1:0]             pend_q;
   logic [NUM_INTR-1:0]             act_q;
   logic [ID_W-1:0]                 cur_id_q;
   logic                            valid_q;

   logic [7:0]                      rd_data;
   logic                            acc_err;
   logic                            wr_commit;
   logic                            svc_done;
   logic [NUM_INTR-1:0]             w1c;
   logic [NUM_INTR-1:0]             svc_clr;
   logic [NUM_INTR-1:0]             elig;
   logic                            found;
   logic [ID_W-1:0]                 win_id;
   logic [PRIO_W-1:0]               win_prio;
   dbg_t                            dbg;

   assign dbg = '{bus: bus_q, svc: svc_q, found: found, win_prio: win_prio};

   // ---------------------------------------------------------------- decode
   always_comb begin
      rd_data = '0;
      acc_err = 1'b1;
      for (int i = 0; i < NUM_INTR; i++) begin
         if (paddr_i == PRIO_BASE + 8'(i)) begin
            rd_data = 8'(prio_q[i]);
            acc_err = 1'b0;
         end
      end
      for (int k = 0; k < NB; k++) begin
         if (paddr_i == EN_BASE + 8'(k)) begin
            rd_data = en_q[k*8 +: 8];
            acc_err = 1'b0;
         end
         if (paddr_i == MODE_BASE + 8'(k)) begin
            rd_data = mode_q[k*8 +: 8];
            acc_err = 1'b0;
         end
         if (paddr_i == PEND_BASE + 8'(k)) begin
            rd_data = pend_q[k*8 +: 8];
            acc_err = 1'b0;
         end
      end
      if (paddr_i == STATUS_ADDR) begin
         rd_data = {valid_q, 2'b00, 5'(cur_id_q)};
         acc_err = pwrite_i;   // STATUS is read-only
      end
   end

   assign wr_commit = (bus_q == BACC) && pwrite_i && !acc_err;
   assign svc_done  = (svc_q == WAIT) && intr_serviced_i;
   assign elig      = pend_q & en_q;

   always_comb begin
      w1c     = '0;
      svc_clr = '0;
      for (int k = 0; k < NB; k++) begin
         if (wr_commit && (paddr_i == PEND_BASE + 8'(k))) begin
            w1c[k*8 +: 8] = pwdata_i;
         end
      end
      for (int i = 0; i < NUM_INTR; i++) begin
         svc_clr[i] = svc_done && (cur_id_q == ID_W'(i));
      end
   end

   // ----------------------------------------------------------- bus FSM
   always_ff @(posedge pclk_i or negedge prst_n_i) begin
      if (!prst_n_i) begin
         bus_q     <= BIDLE;
         pready_o  <= 1'b0;
         prdata_o  <= '0;
         pslverr_o <= 1'b0;
      end else begin
         case (bus_q)
            BIDLE: begin
               if (penable_i) begin
                  bus_q     <= BACC;
                  pready_o  <= 1'b1;
                  prdata_o  <= rd_data;
                  pslverr_o <= acc_err;
               end
            end
            BACC: bus_q <= BHOLD;
            BHOLD: begin
               if (!penable_i) begin
                  bus_q     <= BIDLE;
                  pready_o  <= 1'b0;
                  prdata_o  <= '0;
                  pslverr_o <= 1'b0;
               end
            end
            default: bus_q <= BIDLE;
         endcase
      end
   end

   // ---------------------------------------------------- config registers
   always_ff @(posedge pclk_i or negedge prst_n_i) begin
      if (!prst_n_i) begin
         prio_q <= '0;
         en_q   <= '1;
         mode_q <= '0;
      end else if (wr_commit) begin
         for (int i = 0; i < NUM_INTR; i++) begin
            if (paddr_i == PRIO_BASE + 8'(i)) prio_q[i] <= pwdata_i[PRIO_W-1:0];
         end
         for (int k = 0; k < NB; k++) begin
            if (paddr_i == EN_BASE + 8'(k))   en_q[k*8 +: 8]   <= pwdata_i;
            if (paddr_i == MODE_BASE + 8'(k)) mode_q[k*8 +: 8] <= pwdata_i;
         end
      end
   end

   // ------------------------------------------------------ pending capture
   // Edge sources: a new rising edge is OR-ed in after the clear terms, so a
   // set in the same cycle as a W1C or service clear survives.
   always_ff @(posedge pclk_i or negedge prst_n_i) begin
      if (!prst_n_i) begin
         act_q  <= '0;
         pend_q <= '0;
      end else begin
         act_q  <= intr_active_i;
         pend_q <= (mode_q & ((intr_active_i & ~act_q) | (pend_q & ~(w1c | svc_clr))))
                 | (~mode_q & intr_active_i);
      end
   end

   // ---------------------------------------------------------- arbitration
   intc_prio_arb #(
      .NUM_INTR (NUM_INTR),
      .PRIO_W   (PRIO_W),
      .ID_W     (ID_W)
   ) u_arb (
      .elig     (elig),
      .prio     (prio_q),
      .found    (found),
      .win_id   (win_id),
      .win_prio (win_prio)
   );

`ifdef INTC_PREEMPT_EN
   logic [PRIO_W-1:0] cur_prio;

   // Live priority of the presented source; a PRIO rewrite counts too.
   always_comb begin
      cur_prio = '0;
      for (int i = 0; i < NUM_INTR; i++) begin
         if (cur_id_q == ID_W'(i)) cur_prio = prio_q[i];
      end
   end
`endif

   // ------------------------------------------------------- service FSM
   always_ff @(posedge pclk_i or negedge prst_n_i) begin
      if (!prst_n_i) begin
         svc_q    <= IDLE;
         cur_id_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         case (svc_q)
            IDLE: begin
               if (found) begin
                  cur_id_q <= win_id;
                  valid_q  <= 1'b1;
                  svc_q    <= ISSUE;
               end
            end
            ISSUE: svc_q <= WAIT;
            WAIT: begin
               // Valid is held here even if the source loses eligibility.
               if (intr_serviced_i) begin
                  valid_q <= 1'b0;
                  svc_q   <= IDLE;
               end
`ifdef INTC_PREEMPT_EN
               else if (found && (win_prio > cur_prio)) begin
                  cur_id_q <= win_id;
               end
`endif
            end
            default: begin
               svc_q   <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign intr_to_service_o = cur_id_q;
   assign intr_valid_o      = valid_q;

endmodule

// File: tb/tb_intc_gen2.sv
// -----------------------------------------------------------------------------
// tb_intc_gen2
// Directed and randomized checks of intc_gen2 (NUM_INTR=16, PRIO_W=4).
// Expected service order comes from a small model: among requesting, enabled
// sources pick the largest priority value, then the lowest index holding it.
// -----------------------------------------------------------------------------
module tb_intc_gen2;
   import intc_gen2_pkg::*;

   localparam int NUM    = 16;
   localparam int PRIO_W = 4;
   localparam int ID_W   = 4;

   logic            pclk_i = 1'b0;
   logic            prst_n_i = 1'b0;
   logic [7:0]      paddr_i = '0;
   logic [7:0]      pwdata_i = '0;
   logic            pwrite_i = 1'b0;
   logic            penable_i = 1'b0;
   logic [7:0]      prdata_o;
   logic            pready_o;
   logic            pslverr_o;
   logic [ID_W-1:0] intr_to_service_o;
   logic            intr_valid_o;
   logic            intr_serviced_i = 1'b0;
   logic [NUM-1:0]  intr_active_i = '0;

   int n_assert = 0;
   int n_fail   = 0;
   int prio_m[NUM];

   intc_gen2 #(.NUM_INTR(NUM), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
      .pclk_i            (pclk_i),
      .prst_n_i          (prst_n_i),
      .paddr_i           (paddr_i),
      .pwdata_i          (pwdata_i),
      .pwrite_i          (pwrite_i),
      .penable_i         (penable_i),
      .prdata_o          (prdata_o),
      .pready_o          (pready_o),
      .pslverr_o         (pslverr_o),
      .intr_to_service_o (intr_to_service_o),
      .intr_valid_o      (intr_valid_o),
      .intr_serviced_i   (intr_serviced_i),
      .intr_active_i     (intr_active_i)
   );

   // ------------------------------------------------- clock / watchdog
   always #5 pclk_i = ~pclk_i;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ checker
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------- bus drivers
   // raise is OR-ed into intr_active_i on the cycle the write commits.
   task automatic bus_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [NUM-1:0] raise, output logic [7:0] rdata,
                           output logic err);
      int cyc;
      pwrite_i  = wr;
      paddr_i   = addr;
      pwdata_i  = wdata;
      penable_i = 1'b1;
      cyc = 0;
      do begin @(negedge pclk_i); cyc++; end while (!pready_o && cyc < 8);
      chk("bus_ready", 32'(pready_o), 32'd1);
      rdata = prdata_o;
      err   = pslverr_o;
      intr_active_i = intr_active_i | raise;
      penable_i = 1'b0;
      cyc = 0;
      do begin @(negedge pclk_i); cyc++; end while (pready_o && cyc < 8);
      chk("bus_release", 32'(pready_o), 32'd0);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      logic [7:0] d;
      logic       e;
      bus_xfer(1'b1, addr, data, '0, d, e);
      chk("wr_slverr", 32'(e), 32'd0);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] addr,
                         input logic [7:0] exp_data, input logic exp_err);
      logic [7:0] d;
      logic       e;
      bus_xfer(1'b0, addr, 8'h00, '0, d, e);
      chk({tag, "_data"}, 32'(d), 32'(exp_data));
      chk({tag, "_err"}, 32'(e), 32'(exp_err));
   endtask

   // --------------------------------------------------- service helpers
   task automatic wait_valid(input int max);
      int cyc = 0;
      while (!intr_valid_o && cyc < max) begin @(negedge pclk_i); cyc++; end
   endtask

   task automatic ack();
      int cyc = 0;
      intr_serviced_i = 1'b1;
      do begin @(negedge pclk_i); cyc++; end while (intr_valid_o && cyc < 10);
      intr_serviced_i = 1'b0;
      chk("ack_drop", 32'(intr_valid_o), 32'd0);
   endtask

   // Wait for a presentation, check its ID, drop the level source, acknowledge.
   task automatic serve(input string tag, input int exp_id);
      wait_valid(12);
      chk({tag, "_valid"}, 32'(intr_valid_o), 32'd1);
      chk({tag, "_id"}, 32'(intr_to_service_o), 32'(exp_id));
      intr_active_i[exp_id] = 1'b0;
      @(negedge pclk_i);
      ack();
   endtask

   task automatic drain();
      intr_active_i = '0;
      repeat (2) @(negedge pclk_i);
      if (intr_valid_o) ack();
      repeat (3) @(negedge pclk_i);
      chk("drain_idle", 32'(intr_valid_o), 32'd0);
   endtask

   // ---------------------------------------------------------- model
   function automatic int model_winner(input logic [NUM-1:0] req);
      int top = -1;
      for (int i = 0; i < NUM; i++) if (req[i] && prio_m[i] > top) top = prio_m[i];
      for (int i = 0; i < NUM; i++) if (req[i] && prio_m[i] == top) return i;
      return -1;
   endfunction

   // -------------------------------------------------------- stimulus
   initial begin
      logic [7:0]     d;
      logic           e;
      logic [NUM-1:0] en_m, act_m, remaining, mask, clr;
      logic [7:0]     wd;
      int             exp_id;

      // Reset state
      repeat (3) @(negedge pclk_i);
      chk("rst_valid", 32'(intr_valid_o), 32'd0);
      chk("rst_id", 32'(intr_to_service_o), 32'd0);
      chk("rst_pready", 32'(pready_o), 32'd0);
      chk("rst_pslverr", 32'(pslverr_o), 32'd0);
      chk("rst_prdata", 32'(prdata_o), 32'd0);
      chk("rst_bus_state", 32'(dut.dbg.bus), 32'(BIDLE));
      chk("rst_svc_state", 32'(dut.dbg.svc), 32'(IDLE));
      prst_n_i = 1'b1;
      @(negedge pclk_i);

      // Register map and error responses
      rd_chk("en0_reset", 8'h80, 8'hFF, 1'b0);
      rd_chk("en1_reset", 8'h81, 8'hFF, 1'b0);
      rd_chk("unmapped_50", 8'h50, 8'h00, 1'b1);
      rd_chk("en_past_end", 8'h82, 8'h00, 1'b1);
      rd_chk("mode0_reset", 8'hA0, 8'h00, 1'b0);
      rd_chk("pend0_reset", 8'hC0, 8'h00, 1'b0);
      rd_chk("prio0_reset", 8'h00, 8'h00, 1'b0);
      rd_chk("prio_past_end", 8'h10, 8'h00, 1'b1);
      bus_xfer(1'b1, 8'hE0, 8'hFF, '0, d, e);
      chk("status_wr_err", 32'(e), 32'd1);

      // Priority order and issue latency
      wr(8'h03, 8'h05);
      wr(8'h09, 8'hFC);
      rd_chk("prio9_upper_zero", 8'h09, 8'h0C, 1'b0);
      prio_m[3] = 5;
      prio_m[9] = 12;
      intr_active_i[3] = 1'b1;
      intr_active_i[9] = 1'b1;
      @(negedge pclk_i);
      chk("lat_pend_cycle_valid", 32'(intr_valid_o), 32'd0);
      @(negedge pclk_i);
      chk("lat_issue_valid", 32'(intr_valid_o), 32'd1);
      chk("prio_first_id", 32'(intr_to_service_o), 32'd9);
      rd_chk("status_view", 8'hE0, 8'h89, 1'b0);
      intr_active_i[9] = 1'b0;
      @(negedge pclk_i);
      ack();
      @(negedge pclk_i);
      chk("reissue_valid", 32'(intr_valid_o), 32'd1);
      chk("reissue_id", 32'(intr_to_service_o), 32'd3);

      // Higher-priority arrival while waiting for acknowledge
      intr_active_i[9] = 1'b1;
      repeat (3) @(negedge pclk_i);
`ifdef INTC_PREEMPT_EN
      exp_id = 9;
`else
      exp_id = 3;
`endif
      chk("wait_arrival_valid", 32'(intr_valid_o), 32'd1);
      chk("wait_arrival_id", 32'(intr_to_service_o), 32'(exp_id));
      drain();

      // Equal priority: lowest index first
      wr(8'h02, 8'h07);
      wr(8'h06, 8'h07);
      prio_m[2] = 7;
      prio_m[6] = 7;
      intr_active_i[2] = 1'b1;
      intr_active_i[6] = 1'b1;
      serve("tie_first", 2);
      serve("tie_second", 6);
      repeat (3) @(negedge pclk_i);
      chk("tie_idle", 32'(intr_valid_o), 32'd0);

      // Edge capture, service clear
      wr(8'hA0, 8'h10);
      intr_active_i[4] = 1'b1;
      @(negedge pclk_i);
      intr_active_i[4] = 1'b0;
      rd_chk("pend_edge", 8'hC0, 8'h10, 1'b0);
      wait_valid(12);
      chk("edge_valid", 32'(intr_valid_o), 32'd1);
      chk("edge_id", 32'(intr_to_service_o), 32'd4);
      ack();
      rd_chk("pend_after_ack", 8'hC0, 8'h00, 1'b0);
      chk("edge_no_repeat", 32'(intr_valid_o), 32'd0);

      // W1C alone, then W1C colliding with a new edge
      wr(8'h80, 8'hEF);
      intr_active_i[4] = 1'b1;
      @(negedge pclk_i);
      intr_active_i[4] = 1'b0;
      rd_chk("pend_masked", 8'hC0, 8'h10, 1'b0);
      chk("masked_edge_no_valid", 32'(intr_valid_o), 32'd0);
      wr(8'hC0, 8'h10);
      rd_chk("pend_w1c", 8'hC0, 8'h00, 1'b0);
      bus_xfer(1'b1, 8'hC0, 8'h10, 16'h0010, d, e);
      intr_active_i[4] = 1'b0;
      rd_chk("pend_set_wins", 8'hC0, 8'h10, 1'b0);
      wr(8'h80, 8'hFF);
      wait_valid(12);
      chk("unmask_edge_id", 32'(intr_to_service_o), 32'd4);
      ack();
      wr(8'hA0, 8'h00);

      // Enable mask
      wr(8'h80, 8'hFE);
      intr_active_i[0] = 1'b1;
      repeat (4) @(negedge pclk_i);
      chk("masked_no_valid", 32'(intr_valid_o), 32'd0);
      wr(8'h80, 8'hFF);
      chk("reenable_valid", 32'(intr_valid_o), 32'd1);
      chk("reenable_id", 32'(intr_to_service_o), 32'd0);
      intr_active_i[0] = 1'b0;
      @(negedge pclk_i);
      ack();

      // Randomized level rounds against the model
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NUM; i++) begin
            wd = 8'($urandom_range(0, 255));
            prio_m[i] = int'(wd[PRIO_W-1:0]);
            wr(8'(i), wd);
         end
         en_m = 16'($urandom);
         wr(8'h80, en_m[7:0]);
         wr(8'h81, en_m[15:8]);
         act_m = 16'($urandom);
         intr_active_i = act_m;
         remaining = act_m & en_m;
         while (remaining != '0) begin
            exp_id = model_winner(remaining);
            serve("rand_order", exp_id);
            remaining[exp_id] = 1'b0;
         end
         repeat (4) @(negedge pclk_i);
         chk("rand_idle", 32'(intr_valid_o), 32'd0);
         intr_active_i = '0;
         repeat (2) @(negedge pclk_i);
      end

      // Randomized edge capture and W1C with all sources masked
      wr(8'h80, 8'h00);
      wr(8'h81, 8'h00);
      wr(8'hA0, 8'hFF);
      wr(8'hA1, 8'hFF);
      mask = 16'($urandom);
      intr_active_i = mask;
      @(negedge pclk_i);
      intr_active_i = '0;
      rd_chk("rand_pend0", 8'hC0, mask[7:0], 1'b0);
      rd_chk("rand_pend1", 8'hC1, mask[15:8], 1'b0);
      clr = 16'($urandom);
      wr(8'hC0, clr[7:0]);
      wr(8'hC1, clr[15:8]);
      remaining = mask & ~clr;
      rd_chk("rand_w1c0", 8'hC0, remaining[7:0], 1'b0);
      rd_chk("rand_w1c1", 8'hC1, remaining[15:8], 1'b0);
      wr(8'hC0, 8'hFF);
      wr(8'hC1, 8'hFF);
      wr(8'hA0, 8'h00);
      wr(8'hA1, 8'h00);
      wr(8'h80, 8'hFF);
      wr(8'h81, 8'hFF);

      // Reset in the middle of a service
      intr_active_i[5] = 1'b1;
      wait_valid(12);
      chk("pre_reset_valid", 32'(intr_valid_o), 32'd1);
      prst_n_i = 1'b0;
      #1;
      chk("async_rst_valid", 32'(intr_valid_o), 32'd0);
      chk("async_rst_id", 32'(intr_to_service_o), 32'd0);
      intr_active_i = '0;
      @(negedge pclk_i);
      prst_n_i = 1'b1;
      @(negedge pclk_i);
      rd_chk("en_after_rst", 8'h80, 8'hFF, 1'b0);
      rd_chk("prio9_after_rst", 8'h09, 8'h00, 1'b0);
      chk("idle_after_rst", 32'(intr_valid_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
